// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage with one-entry decode slot, redirect and halt.
module fetch_unit #(
   parameter int                 ADDR_W   = 16,
   parameter int                 INSTR_W  = 16,
   parameter logic [ADDR_W-1:0]  RESET_PC = 16'h0000,
   parameter logic [INSTR_W-1:0] HALT_OP  = 16'hFFFF
) (
   input  logic               clk,
   input  logic               rst_n,
   output logic [ADDR_W-1:0]  pc,
   input  logic [INSTR_W-1:0] instr_in,
   input  logic               redir_valid,
   input  logic [ADDR_W-1:0]  redir_target,
   output logic               id_valid,
   input  logic               id_ready,
   output logic [INSTR_W-1:0] id_instr,
   output logic [ADDR_W-1:0]  id_pc,
   output logic               halted,
   output logic               misalign,
   output logic [15:0]        fetch_cnt
);

   typedef enum logic [1:0] {
      BUBBLE = 2'd0,
      RUN    = 2'd1,
      HALT   = 2'd2
   } state_t;

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   pc_q, pc_d;
   logic                id_valid_q, id_valid_d;
   logic [INSTR_W-1:0]  id_instr_q, id_instr_d;
   logic [ADDR_W-1:0]   id_pc_q, id_pc_d;
   logic                misalign_q, misalign_d;
   logic [15:0]         fetch_cnt_q, fetch_cnt_d;

   logic                accept;
   logic                slot_free;

   assign accept    = id_valid_q && id_ready;
   assign slot_free = !id_valid_q || id_ready;

   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      id_valid_d  = id_valid_q;
      id_instr_d  = id_instr_q;
      id_pc_d     = id_pc_q;
      misalign_d  = misalign_q;
      fetch_cnt_d = fetch_cnt_q;

      if (redir_valid) begin
         // Redirect flushes the slot and wins over stall, capture and halt.
         state_d    = RUN;
         pc_d       = {redir_target[ADDR_W-1:1], 1'b0};
         id_valid_d = 1'b0;
         if (redir_target[0]) begin
            misalign_d = 1'b1;
         end
      end else begin
         if (accept && fetch_cnt_q != 16'hFFFF) begin
            fetch_cnt_d = fetch_cnt_q + 16'd1;
         end
         case (state_q)
            BUBBLE: begin
               state_d = RUN;
               if (accept) begin
                  id_valid_d = 1'b0;
               end
            end
            RUN: begin
               if (slot_free) begin
                  id_instr_d = instr_in;
                  id_pc_d    = pc_q;
                  id_valid_d = 1'b1;
                  if (instr_in == HALT_OP) begin
                     state_d = HALT;
                  end else begin
                     pc_d = pc_q + ADDR_W'(2);
                  end
               end
            end
            HALT: begin
               if (accept) begin
                  id_valid_d = 1'b0;
               end
            end
            default: begin
               state_d    = BUBBLE;
               id_valid_d = 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= BUBBLE;
         pc_q        <= RESET_PC;
         id_valid_q  <= 1'b0;
         id_instr_q  <= '0;
         id_pc_q     <= '0;
         misalign_q  <= 1'b0;
         fetch_cnt_q <= 16'd0;
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         id_valid_q  <= id_valid_d;
         id_instr_q  <= id_instr_d;
         id_pc_q     <= id_pc_d;
         misalign_q  <= misalign_d;
         fetch_cnt_q <= fetch_cnt_d;
      end
   end

   assign pc        = pc_q;
   assign id_valid  = id_valid_q;
   assign id_instr  = id_instr_q;
   assign id_pc     = id_pc_q;
   assign halted    = (state_q == HALT);
   assign misalign  = misalign_q;
   assign fetch_cnt = fetch_cnt_q;

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter ADDR_W, default 16, meaning PC / byte-address width.
REQ-002 SHALL have parameter INSTR_W, default 16, meaning instruction width (2 bytes per instruction).
REQ-003 SHALL have parameter RESET_PC, default 16'h0000, meaning first fetch address after reset.
REQ-004 SHALL have parameter HALT_OP, default 16'hFFFF, meaning the encoding that halts fetch.
REQ-005 SHALL have one clock and an asynchronous, active-low reset; ports: clk  in  1  rising-edge clock; rst_n  in  1  asynchronous active-low reset.
REQ-006 SHALL have ports: pc  out  ADDR_W  address driven to instruction memory; instr_in  in  INSTR_W  combinational memory read data for pc.
REQ-007 SHALL have ports: redir_valid  in  1  branch/jump redirect request; redir_target  in  ADDR_W  redirect byte address.
REQ-008 SHALL have ports: id_valid  out  1  decode-stage slot holds an instruction; id_ready  in  1  decode accepts this cycle; id_instr  out  INSTR_W  held instruction; id_pc  out  ADDR_W  address of id_instr.
REQ-009 SHALL have ports: halted  out  1  fetch stopped on HALT_OP; misalign  out  1  sticky odd-redirect flag; fetch_cnt  out  16  instructions accepted by decode.

Function
REQ-010 SHALL implement states BUBBLE, RUN, HALT; BUBBLE is the state for exactly one cycle after reset release, during which nothing is captured, then RUN.
REQ-011 SHALL, in RUN, capture instr_in and pc into id_instr/id_pc, set id_valid=1 and advance pc by 2 on a clock edge where (id_valid==0 or id_ready==1) and redir_valid==0.
REQ-012 SHALL hold pc, id_instr, id_pc and id_valid unchanged while id_valid==1 and id_ready==0 (stall), with no redirect.
REQ-013 SHALL clear id_valid when id_valid==1, id_ready==1 and no new capture occurs (BUBBLE or HALT).
REQ-014 SHALL wrap pc modulo 2^ADDR_W (0xFFFE+2 -> 0x0000), with no flag.
REQ-015 SHALL, on redir_valid==1 in any state, at the next edge load pc with {redir_target[ADDR_W-1:1],1'b0}, clear id_valid (flush, regardless of id_ready), and enter RUN; redirect takes priority over stall, capture and HALT.
REQ-016 SHALL set misalign on a redirect with redir_target[0]==1; cleared only by reset.
REQ-017 SHALL, when a captured instruction equals HALT_OP, enter HALT on that edge with pc not advanced; HALT_OP is still presented on id_instr with id_valid=1.
REQ-018 SHALL in HALT perform no captures, hold pc, assert halted=1; the pending HALT_OP is consumed normally (REQ-013); exit only via redirect or reset.
REQ-019 SHALL increment fetch_cnt on each edge with id_valid==1 and id_ready==1 and no redirect, saturating at 16'hFFFF.
REQ-020 SHALL have pc combinationally equal to the pc register (zero-latency to memory); instruction at pc reaches id_instr one edge later.

Reset
REQ-021 SHALL, while rst_n==0, asynchronously force pc=RESET_PC, id_valid=0, id_instr=0, id_pc=0, halted=0, misalign=0, fetch_cnt=0, state=BUBBLE.
REQ-022 SHALL, on reset asserted mid-operation (including during stall or HALT), discard the held instruction and restart per REQ-010 after release.

Verification
REQ-023 SHALL cover: reset release, id_ready=1, memory returns pc-indexed words -> id_valid first high on 2nd edge with id_pc=0x0000, then id_pc 0x0002, 0x0004... each cycle; fetch_cnt increments each cycle.
REQ-024 SHALL cover: id_ready=0 for 3 cycles with id_pc=0x0006 -> pc held 0x0008, id_instr/id_pc unchanged, fetch_cnt unchanged; id_ready=1 resumes with id_pc=0x0008.
REQ-025 SHALL cover: redir_valid=1, redir_target=0x0041 during a stall -> next edge pc=0x0040, id_valid=0, misalign=1; following edge id_pc=0x0040.
REQ-026 SHALL cover: instr_in=16'hFFFF at pc=0x0010 -> id_instr=FFFF, halted=1, pc stays 0x0010; after acceptance id_valid=0 permanently until redirect to 0x0000 restores RUN.
REQ-027 SHALL cover: pc=0xFFFE with id_ready=1 -> next pc=0x0000 and id_pc=0xFFFE.
REQ-028 SHALL cover: rst_n pulsed low mid-stall, asynchronous to clk -> outputs take REQ-021 values immediately, without waiting for a clock edge.
